// File: rtl/window_min_select.sv
// -----------------------------------------------------------------------------
// window_min_select
//   Consumer on the read side of the clk1->clk2 async FIFO (first-word
//   fall-through). Pops {account, A, T} records, forms prod = A*T and, over a
//   sliding window of WIN consecutive records, reports the account with the
//   minimum product. One result per record from the WIN-th record of a frame
//   onward; the window is rebuilt from scratch after every TOTAL records.
//
//   Optional feature: define WMS_MIN_PROD_OUT_EN to add out_prod, the winning
//   product, updated with the same timing as out_account.
//
// Ports
//   clk          clk2-domain clock
//   rst_n        asynchronous active-low reset
//   rempty       FIFO empty; rdata valid whenever rempty=0
//   rdata        {account, A, T}, DSIZE bits each
//   rinc         FIFO pop strobe (rst_n & ~rempty)
//   out_valid    one-cycle pulse per result
//   out_account  account holding the window minimum, held between pulses
//   out_prod     winning product (only with WMS_MIN_PROD_OUT_EN)
// -----------------------------------------------------------------------------
module window_min_select #(
    parameter int DSIZE = 8,
    parameter int WIN   = 5,
    parameter int TOTAL = 4000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rempty,
    input  logic [3*DSIZE-1:0] rdata,
    output logic               rinc,
    output logic               out_valid,
    output logic [DSIZE-1:0]   out_account
`ifdef WMS_MIN_PROD_OUT_EN
    ,
    output logic [2*DSIZE-1:0] out_prod
`endif
);

    localparam int PW = 2 * DSIZE;
    localparam int CW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int FW = $clog2(WIN);

    typedef struct packed {
        logic [DSIZE-1:0] acct;
        logic [PW-1:0]    prod;
    } ent_t;

    logic [DSIZE-1:0] rd_acct, rd_a, rd_t;
    logic [PW-1:0]    prod_in;

    logic             s1_vld;
    logic             s1_last;    // S1 holds the final record of its frame
    ent_t             s1;
    ent_t [WIN-2:0]   win_q;      // index 0 = oldest held entry
    logic [FW-1:0]    fill;       // records shifted into the window this frame
    logic [CW-1:0]    frame_cnt;
    ent_t             best;

    assign rd_acct = rdata[3*DSIZE-1:2*DSIZE];
    assign rd_a    = rdata[2*DSIZE-1:DSIZE];
    assign rd_t    = rdata[DSIZE-1:0];
    assign prod_in = PW'(rd_a) * PW'(rd_t);

    // No backpressure: pop whenever data is present and we are out of reset.
    assign rinc = rst_n & ~rempty;

    // Oldest->newest scan with <=, so the newest of equal products wins.
    // The incoming S1 entry is the newest candidate.
    always_comb begin
        best = win_q[0];
        for (int i = 1; i < WIN - 1; i++) begin
            if (win_q[i].prod <= best.prod) best = win_q[i];
        end
        if (s1.prod <= best.prod) best = s1;
    end

    // Frame counter over pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (rinc) begin
            frame_cnt <= (frame_cnt == CW'(TOTAL - 1)) ? '0 : frame_cnt + 1'b1;
        end
    end

    // S1: register the popped record and its product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1      <= '0;
        end else begin
            s1_vld <= rinc;
            if (rinc) begin
                s1.acct <= rd_acct;
                s1.prod <= prod_in;
                s1_last <= (frame_cnt == CW'(TOTAL - 1));
            end
        end
    end

    // S2: select, shift window, report once the window is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            fill        <= '0;
            out_valid   <= 1'b0;
            out_account <= '0;
`ifdef WMS_MIN_PROD_OUT_EN
            out_prod    <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (s1_vld) begin
                for (int i = 0; i < WIN - 2; i++) win_q[i] <= win_q[i + 1];
                win_q[WIN-2] <= s1;
                if (fill == FW'(WIN - 1)) begin
                    out_valid   <= 1'b1;
                    out_account <= best.acct;
`ifdef WMS_MIN_PROD_OUT_EN
                    out_prod    <= best.prod;
`endif
                end else begin
                    fill <= fill + 1'b1;
                end
                // Last record of the frame still reports, but the next frame
                // starts with an empty window.
                if (s1_last) fill <= '0;
            end
        end
    end

endmodule

// File: tb/tb_window_min_select.sv
module tb_window_min_select;

    localparam int DSIZE = 8;
    localparam int WIN   = 5;
    localparam int TOTAL = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rempty;
    logic [23:0] rdata;
    logic        rinc;
    logic        out_valid;
    logic [7:0]  out_account;
`ifdef WMS_MIN_PROD_OUT_EN
    logic [15:0] out_prod;
`endif

    window_min_select #(.DSIZE(DSIZE), .WIN(WIN), .TOTAL(TOTAL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rempty      (rempty),
        .rdata       (rdata),
        .rinc        (rinc),
        .out_valid   (out_valid),
        .out_account (out_account)
`ifdef WMS_MIN_PROD_OUT_EN
        ,
        .out_prod    (out_prod)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int acct;
        int prod;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;

    // reference model state for the randomized frames
    int   m_acct[$];
    int   m_prod[$];
    int   m_k = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", int'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_account", int'(out_account), e.acct);
                chk("latency", cyc, e.cyc);
`ifdef WMS_MIN_PROD_OUT_EN
                chk("out_prod", int'(out_prod), e.prod);
`endif
            end
        end
        cyc++;
    end

    task automatic model_clear();
        m_acct.delete();
        m_prod.delete();
        m_k = 0;
    endtask

    task automatic do_reset();
        rempty = 1'b0;
        rst_n  = 1'b0;
        exp_q.delete();
        model_clear();
        #30;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_account", int'(out_account), 0);
        chk("rst_rinc", int'(rinc), 0);
        rempty = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        rempty = 1'b1;
        if (n > 0) begin
            #1 chk("rinc_idle", int'(rinc), 0);
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Present one record; it is popped at the next rising edge.
    task automatic push_d(input int acct, input int a, input int t,
                          input bit ev, input int ea, input int ep);
        rempty = 1'b0;
        rdata  = {acct[7:0], a[7:0], t[7:0]};
        #1 chk("rinc_pop", int'(rinc), 1);
        @(posedge clk);
        #1;
        if (ev) exp_q.push_back('{ea, ep, cyc + 1});
        rempty = 1'b1;
    endtask

    // Model: newest-to-oldest scan with strict <, so the newest tie wins.
    task automatic push_m(input int acct, input int a, input int t);
        int ba, bp;
        bit ev;
        m_acct.push_back(acct);
        m_prod.push_back(a * t);
        if (m_acct.size() > WIN) begin
            void'(m_acct.pop_front());
            void'(m_prod.pop_front());
        end
        ev = (m_k >= WIN - 1);
        ba = m_acct[m_acct.size() - 1];
        bp = m_prod[m_prod.size() - 1];
        for (int j = m_acct.size() - 2; j >= 0; j--) begin
            if (m_prod[j] < bp) begin
                bp = m_prod[j];
                ba = m_acct[j];
            end
        end
        push_d(acct, a, t, ev, ba, bp);
        m_k++;
        if (m_k == TOTAL) model_clear();
    endtask

    task automatic basic_pattern();
        push_d(1, 5, 10, 0, 0, 0);
        push_d(2, 4, 10, 0, 0, 0);
        push_d(3, 3, 10, 0, 0, 0);
        push_d(4, 2, 10, 0, 0, 0);
        push_d(5, 1, 10, 1, 5, 10);
        push_d(6, 6, 10, 1, 5, 10);
        idle(4);
        chk("basic_pending", exp_q.size(), 0);
    endtask

    initial begin
        int base, gap;
        rst_n  = 1'b0;
        rempty = 1'b1;
        rdata  = '0;
        do_reset();

        // Decreasing products, back-to-back; result held between pulses.
        basic_pattern();
        chk("acct_hold", int'(out_account), 5);
        do_reset();

        // Tie on product 3: newest (acct 13) wins.
        push_d(10, 3, 3, 0, 0, 0);
        push_d(11, 1, 3, 0, 0, 0);
        push_d(12, 7, 1, 0, 0, 0);
        push_d(13, 3, 1, 0, 0, 0);
        push_d(14, 2, 4, 1, 13, 3);
        idle(4);
        chk("tie_pending", exp_q.size(), 0);
        do_reset();

        // Eviction: acct 1 (prod 1) reported five times, then acct 2.
        for (int i = 0; i < 4; i++) push_d(50 + i, 200, 1, 0, 0, 0);
        push_d(1, 1, 1, 1, 1, 1);
        push_d(2, 100, 1, 1, 1, 1);
        push_d(3, 101, 1, 1, 1, 1);
        push_d(4, 102, 1, 1, 1, 1);
        push_d(5, 103, 1, 1, 1, 1);
        push_d(6, 104, 1, 1, 2, 100);
        idle(4);
        chk("evict_pending", exp_q.size(), 0);
        do_reset();

        // Full-scale operands: 65025 vs 64770 and all-65025 ties.
        push_d(30, 255, 255, 0, 0, 0);
        push_d(31, 255, 254, 0, 0, 0);
        push_d(32, 255, 255, 0, 0, 0);
        push_d(33, 255, 255, 0, 0, 0);
        push_d(34, 255, 255, 1, 31, 64770);
        push_d(35, 255, 255, 1, 31, 64770);
        push_d(36, 255, 255, 1, 36, 65025);
        push_d(37, 255, 254, 1, 37, 64770);
        idle(4);
        chk("max_pending", exp_q.size(), 0);
        do_reset();

        // Full frame with random gaps, then the start of the next frame.
        base = pulse_cnt;
        idle(150);
        for (int i = 0; i < TOTAL; i++) begin
            push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            gap = ($urandom_range(0, 39) == 0) ? $urandom_range(1, 150) : $urandom_range(0, 1);
            idle(gap);
        end
        idle(4);
        chk("frame_pulses", pulse_cnt - base, TOTAL - WIN + 1);
        chk("frame_pending", exp_q.size(), 0);
        for (int i = 0; i < WIN + 1; i++) begin
            push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            idle($urandom_range(0, 3));
        end
        idle(4);
        chk("frame2_pulses", pulse_cnt - base, TOTAL - WIN + 3);
        chk("frame2_pending", exp_q.size(), 0);
        do_reset();

        // Reset mid-frame after 2000 pops; next frame restarts at record 0.
        for (int i = 0; i < 2000; i++)
            push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        rempty = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_rinc", int'(rinc), 0);
        do_reset();
        basic_pattern();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
